spi_tx: RTL and testbench
=========================

# spi_tx

Mode-1 SPI (CPOL=0, CPHA=1) transmit shifter: accepts a WIDTH-bit word over a valid/ready handshake and serialises it MSB-first on MOSI. MOSI changes after each SCLK rising edge, so the peripheral samples it on the falling edge. SCLK is generated elsewhere in the SPI master and observed here as a plain input. The block sits beside `spi_rx` in the master datapath and is the transmit counterpart of the MISO receiver.

## Interface
- `WIDTH`, 8, bits per frame (≥2)
- `clock_i`  in  1  system clock; everything sampled on rising edge
- `reset_i`  in  1  reset, synchronous and active-high
- `tx_valid_i`  in  1  word on `tx_data_i` is offered
- `tx_ready_o`  out  1  block can accept a word (IDLE only)
- `tx_data_i`  in  WIDTH  word to send, MSB first
- `SCLK_i`  in  1  serial clock from the master clock generator, idles low
- `MOSI_o`  out  1  serial data out, registered
- `busy_o`  out  1  frame in progress (ARMED or SHIFT)
- `done_o`  out  1  one-cycle pulse: last bit has been sampled by the peripheral

## Operation
- SCLK edge pulses:
  - `rise = SCLK_i & ~sclk_q`
  - `fall = ~SCLK_i & sclk_q`
  - `sclk_q` is the registered SCLK_i, reset 0.
  - The two pulses are mutually exclusive by construction.
- States:
  - IDLE: `tx_ready_o=1`, `MOSI_o=0`. On `tx_valid_i & tx_ready_o`: latch `tx_data_i` into the shift register, clear `bit_cnt`, go to ARMED.
  - ARMED: wait for `rise`. On `rise`: `MOSI_o <= shreg[WIDTH-1]`, shift left with 0 fill, `bit_cnt <= 1`, go to SHIFT. A `fall` in this state is ignored.
  - SHIFT:
    - On `rise` with `bit_cnt < WIDTH`: drive the next MSB, shift, increment `bit_cnt`.
    - On `fall` with `bit_cnt == WIDTH`: go to DONE.
    - Any other edge changes nothing.
  - DONE: `done_o=1`, `MOSI_o <= 0`, go to IDLE.
- `busy_o` is high in ARMED and SHIFT.
- `bit_cnt` width is `$clog2(WIDTH+1)`. It never exceeds WIDTH. A `rise` in SHIFT with `bit_cnt == WIDTH` is ignored (extra SCLK cycles transmit nothing).
- `tx_data_i` is ignored except in the accept cycle. A word offered in a non-IDLE state is not accepted and stays pending at the source.
- SCLK edges in IDLE and DONE are ignored.

## Timing
- Reset values:
  - Outputs: `tx_ready_o=1`, `MOSI_o=0`, `busy_o=0`, `done_o=0`.
  - Internal: state IDLE, `sclk_q=0`, shift register 0, `bit_cnt=0`.
- Reset mid-frame: the frame is dropped with no `done_o`. The next cycle is IDLE with all outputs at their reset values.
- Accept takes one cycle. `tx_ready_o` is low from the cycle after accept until the cycle after DONE.
- `MOSI_o` updates on the clock edge ending the cycle in which `rise` is high, i.e. one clock after SCLK_i is seen high. SCLK half-period must be ≥3 clocks so that MOSI is stable before the falling edge.
- `done_o` is high for exactly one cycle: the cycle after the `fall` that follows the WIDTH-th `rise`.
- Back-to-back frames:
  - DONE→IDLE costs one cycle, so a new word is accepted at the earliest in the cycle after `done_o`.
  - If the master keeps SCLK running, its first rising edge is used only once the block is in ARMED.

## Structure
- Shared package `spi_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} spi_tx_state_t`
  - `SPI_MOSI_IDLE = 1'b0`
- Sub-module: reuse the existing `edge_trigger`, two instances:
  - `DETECT_POS_EDGE(1)` gives `rise`
  - `DETECT_POS_EDGE(0)` gives `fall`
  - Its pulse timing must match the `rise`/`fall` definition above; otherwise implement the `sclk_q` register locally.
- The FSM, shift register and counter are local. No other new modules.

## Test plan
- Reset, then accept `8'hA5`. Drive 8 SCLK periods with half-period 4 clocks. Required: MOSI sequence 1,0,1,0,0,1,0,1 sampled at each falling edge; `done_o` one cycle after the 8th fall; `tx_ready_o` back to 1.
- Assert `tx_valid_i` with `8'hFF` while in SHIFT. Required: not accepted and the current frame is unaffected. The word is accepted in the first IDLE cycle after `done_o`, then sent as eight 1s.
- Toggle SCLK for 3 periods in IDLE, then accept `8'h80`. Required: MOSI stays 0 during the idle toggles, then sends 1 followed by seven 0s; exactly one `done_o`.
- Assert `reset_i` for 1 cycle after the 4th rise of frame `8'h3C`. Required: next cycle `MOSI_o=0`, `busy_o=0`, `tx_ready_o=1`, and no `done_o`.
- Run 10 SCLK periods for frame `8'hC3`. Required: `done_o` after the 8th fall; rises 9–10 leave `MOSI_o=0` and cause no state change.
- `WIDTH=16`, frame `16'h8001`. Required: 1, fourteen 0s, 1; `done_o` after the 16th fall.

Source files
------------

// File: rtl/spi_pkg.sv
// ------------------------------------------------------------------
// spi_pkg: shared types and constants for the SPI master datapath
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_tx_state_t;

   localparam logic SPI_MOSI_IDLE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spi_tx.sv
// ------------------------------------------------------------------
// spi_tx: Mode-1 (CPOL=0, CPHA=1) SPI transmit shifter, MSB first
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module spi_tx
   import spi_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             SCLK_i,
   output logic             MOSI_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int              CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   c_WIDTH = CW'(WIDTH);

   spi_tx_state_t    r_state, w_state_nxt;
   logic             r_sclk_q;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
   logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic             r_mosi, w_mosi_nxt;
   logic             w_rise, w_fall;

   // SCLK is sampled once per system clock; the edge pulses are exclusive
   assign w_rise = SCLK_i & ~r_sclk_q;
   assign w_fall = ~SCLK_i & r_sclk_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_sclk_q  <= 1'b0;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_mosi    <= SPI_MOSI_IDLE;
      end else begin
         r_state   <= w_state_nxt;
         r_sclk_q  <= SCLK_i;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_mosi    <= w_mosi_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_mosi_nxt    = r_mosi;
      case (r_state)
         IDLE: begin
            if (tx_valid_i) begin
               w_shreg_nxt   = tx_data_i;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ARMED;
            end
         end
         ARMED: begin
            if (w_rise) begin
               w_mosi_nxt    = r_shreg[WIDTH-1];
               w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
               w_bit_cnt_nxt = CW'(1);
               w_state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            // Rises beyond the last bit are surplus SCLK cycles and send nothing
            if (w_rise && (r_bit_cnt < c_WIDTH)) begin
               w_mosi_nxt    = r_shreg[WIDTH-1];
               w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
               w_bit_cnt_nxt = r_bit_cnt + CW'(1);
            end else if (w_fall && (r_bit_cnt == c_WIDTH)) begin
               w_state_nxt   = DONE;
            end
         end
         DONE: begin
            w_mosi_nxt  = SPI_MOSI_IDLE;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign tx_ready_o = (r_state == IDLE);
   assign busy_o     = (r_state == ARMED) || (r_state == SHIFT);
   assign done_o     = (r_state == DONE);
   assign MOSI_o     = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx.sv
// ------------------------------------------------------------------
// tb_spi_tx: directed, table-driven check of spi_tx (WIDTH 8 and 16)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_spi_tx;

   logic        clk;
   logic        rst;
   logic        sclk;
   logic        valid8, valid16;
   logic [7:0]  data8;
   logic [15:0] data16;
   logic        ready8, ready16, mosi8, mosi16, busy8, busy16, done8, done16;

   int cyc;
   int dcnt8, dcnt16, ld8, ld16;
   int checks;
   int errors;

   spi_tx #(.WIDTH(8)) u_dut8 (
      .clock_i(clk), .reset_i(rst), .tx_valid_i(valid8), .tx_ready_o(ready8),
      .tx_data_i(data8), .SCLK_i(sclk), .MOSI_o(mosi8), .busy_o(busy8), .done_o(done8)
   );

   spi_tx #(.WIDTH(16)) u_dut16 (
      .clock_i(clk), .reset_i(rst), .tx_valid_i(valid16), .tx_ready_o(ready16),
      .tx_data_i(data16), .SCLK_i(sclk), .MOSI_o(mosi16), .busy_o(busy16), .done_o(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done8) begin
         dcnt8 = dcnt8 + 1;
         ld8   = cyc;
      end
      if (done16) begin
         dcnt16 = dcnt16 + 1;
         ld16   = cyc;
      end
   end

   typedef struct {
      logic [15:0] data;
      int          w;
      int          nper;
      logic [31:0] exp_bits;
   } vec_t;

   vec_t vecs [4];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic rd_mosi(input int sel);
      return (sel != 0) ? mosi16 : mosi8;
   endfunction

   task automatic accept(input int sel, input logic [15:0] d);
      chk("ready_before_accept", (sel != 0) ? ready16 : ready8, 1);
      if (sel != 0) begin
         valid16 = 1'b1; data16 = d;
      end else begin
         valid8 = 1'b1; data8 = d[7:0];
      end
      tick(1);
      valid8 = 1'b0; valid16 = 1'b0;
      chk("busy_after_accept", (sel != 0) ? busy16 : busy8, 1);
      chk("ready_after_accept", (sel != 0) ? ready16 : ready8, 0);
   endtask

   // nper SCLK periods (half-period 4 clocks); MOSI captured just before each fall
   task automatic run_frame(input int sel, input int nper, input int w,
                            output logic [31:0] cap, output int nd, output int ddly);
      int d0;
      int fcyc;
      cap  = '0;
      d0   = (sel != 0) ? dcnt16 : dcnt8;
      fcyc = 0;
      for (int p = 0; p < nper; p++) begin
         sclk = 1'b1;
         tick(3);
         cap = {cap[30:0], rd_mosi(sel)};
         tick(1);
         sclk = 1'b0;
         if (p == w - 1) fcyc = cyc;
         tick(4);
      end
      nd   = ((sel != 0) ? dcnt16 : dcnt8) - d0;
      ddly = ((sel != 0) ? ld16 : ld8) - fcyc;
   endtask

   logic [31:0] cap;
   logic [31:0] cap1;
   int          nd, ddly, d0;
   int          sel;

   initial begin
      vecs[0] = '{data: 16'h00A5, w: 8,  nper: 8,  exp_bits: 32'h000000A5};
      vecs[1] = '{data: 16'h0080, w: 8,  nper: 8,  exp_bits: 32'h00000080};
      vecs[2] = '{data: 16'h00C3, w: 8,  nper: 10, exp_bits: 32'h0000030C};
      vecs[3] = '{data: 16'h8001, w: 16, nper: 16, exp_bits: 32'h00008001};

      checks = 0; errors = 0;
      dcnt8 = 0; dcnt16 = 0; ld8 = 0; ld16 = 0; cyc = 0;
      rst = 1'b1; sclk = 1'b0;
      valid8 = 1'b0; valid16 = 1'b0; data8 = '0; data16 = '0;
      tick(3);
      rst = 1'b0;
      tick(1);

      chk("reset_ready8", ready8, 1);
      chk("reset_mosi8",  mosi8,  0);
      chk("reset_busy8",  busy8,  0);
      chk("reset_done8",  done8,  0);
      chk("reset_ready16", ready16, 1);
      chk("reset_mosi16",  mosi16,  0);
      chk("reset_busy16",  busy16,  0);

      // SCLK toggling while idle must not move MOSI or start anything
      d0 = dcnt8;
      for (int p = 0; p < 3; p++) begin
         sclk = 1'b1;
         tick(4);
         chk("idle_toggle_mosi", mosi8, 0);
         chk("idle_toggle_busy", busy8, 0);
         sclk = 1'b0;
         tick(4);
      end
      chk("idle_toggle_done", dcnt8 - d0, 0);

      for (int v = 0; v < 4; v++) begin
         sel = (vecs[v].w == 16) ? 1 : 0;
         accept(sel, vecs[v].data);
         run_frame(sel, vecs[v].nper, vecs[v].w, cap, nd, ddly);
         chk($sformatf("v%0d_mosi_bits", v), cap, vecs[v].exp_bits);
         chk($sformatf("v%0d_done_count", v), nd, 1);
         chk($sformatf("v%0d_done_delay", v), ddly, 1);
         chk($sformatf("v%0d_ready_end", v), (sel != 0) ? ready16 : ready8, 1);
         chk($sformatf("v%0d_busy_end", v), (sel != 0) ? busy16 : busy8, 0);
         chk($sformatf("v%0d_mosi_end", v), rd_mosi(sel), 0);
      end

      // Word offered during SHIFT is held off and taken right after done
      accept(0, 16'h0069);
      sclk = 1'b1;
      tick(3);
      cap1 = {31'd0, mosi8};
      tick(1);
      sclk = 1'b0;
      tick(4);
      valid8 = 1'b1; data8 = 8'hFF;
      chk("pend_ready_in_shift", ready8, 0);
      tick(1);
      chk("pend_busy_in_shift", busy8, 1);
      run_frame(0, 7, 7, cap, nd, ddly);
      chk("pend_first_frame_bits", {cap1[0], cap[6:0]}, 32'h69);
      chk("pend_first_done_count", nd, 1);
      chk("pend_first_done_delay", ddly, 1);
      valid8 = 1'b0; data8 = 8'h00;
      chk("pend_accepted_busy", busy8, 1);
      chk("pend_accepted_ready", ready8, 0);
      run_frame(0, 8, 8, cap, nd, ddly);
      chk("pend_second_bits", cap, 32'hFF);
      chk("pend_second_done_count", nd, 1);
      chk("pend_second_done_delay", ddly, 1);
      chk("pend_second_ready_end", ready8, 1);

      // Reset right after the 4th rise of 8'h3C drops the frame silently
      accept(0, 16'h003C);
      run_frame(0, 3, 8, cap, nd, ddly);
      chk("rst_first_bits", cap, 32'h1);
      d0 = dcnt8;
      sclk = 1'b1;
      tick(3);
      chk("rst_mosi_before", mosi8, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_mosi_after",  mosi8,  0);
      chk("rst_busy_after",  busy8,  0);
      chk("rst_ready_after", ready8, 1);
      sclk = 1'b0;
      tick(4);
      for (int p = 0; p < 4; p++) begin
         sclk = 1'b1;
         tick(4);
         chk("rst_mosi_idle", mosi8, 0);
         sclk = 1'b0;
         tick(4);
      end
      chk("rst_no_done", dcnt8 - d0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
